// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder: the default operand width and
// the controller state encoding. Imported by serial_adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/oneBitFA2.sv
// oneBitFA2
// One-bit full-adder cell.
// Ports:
//   a_i, b_i  - addend bits
//   ci_i      - carry-in
//   sum_o     - sum bit
//   co_o      - carry-out
module oneBitFA2 (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic sum_o,
  output logic co_o
);

  logic half_s;

  assign half_s = a_i ^ b_i;
  assign sum_o  = half_s ^ ci_i;
  assign co_o   = (a_i & b_i) | (ci_i & half_s);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial adder: computes a_i + b_i + ci_i one bit per clock, LSB first,
// through a single full-adder cell and a carry flop.
// Ports:
//   clk_i    - clock, all state changes on the rising edge
//   rst_i    - synchronous active-high reset
//   start_i  - begin an addition (honoured in IDLE and DONE only)
//   a_i/b_i  - operands, captured on an accepted start
//   ci_i     - carry-in, captured on an accepted start
//   busy_o   - high while bits are being processed
//   done_o   - one-cycle pulse marking a new result
//   sum_o    - result of the last completed addition (mod 2^WIDTH)
//   co_o     - carry-out of the last completed addition
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_r;
  state_e           state_nx_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_sh_r;
  logic [WIDTH-1:0] res_sh_nx_s;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sum_r;
  logic             co_r;
  logic             fa_sum_s;
  logic             fa_co_s;
  logic             last_bit_s;

  oneBitFA2 u_fa (
    .a_i   (a_sh_r[0]),
    .b_i   (b_sh_r[0]),
    .ci_i  (carry_r),
    .sum_o (fa_sum_s),
    .co_o  (fa_co_s)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign res_sh_nx_s = {fa_sum_s, res_sh_r[WIDTH-1:1]};
  assign last_bit_s  = (cnt_r == LAST_CNT);

  // Next-state logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start_i) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_bit_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath: operand/result shift registers, carry flop, bit counter, result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      res_sh_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      sum_r    <= '0;
      co_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start_i) begin
            a_sh_r  <= a_i;
            b_sh_r  <= b_i;
            carry_r <= ci_i;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          a_sh_r   <= a_sh_r >> 1;
          b_sh_r   <= b_sh_r >> 1;
          res_sh_r <= res_sh_nx_s;
          carry_r  <= fa_co_s;
          cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          // Results are published only when the final bit completes.
          if (last_bit_s) begin
            sum_r <= res_sh_nx_s;
            co_r  <= fa_co_s;
          end
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign busy_o = (state_r == RUN);
  assign done_o = (state_r == DONE);
  assign sum_o  = sum_r;
  assign co_o   = co_r;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Directed bench for serial_adder (WIDTH=8) with an arithmetic transaction
// model compared every cycle, plus an exhaustive WIDTH=4 sweep.
module tb_serial_adder;

  localparam int W  = 8;
  localparam int W4 = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         ci;
  logic         busy, done, co;
  logic [W-1:0] sum;

  logic          start4;
  logic [W4-1:0] a4, b4;
  logic          ci4;
  logic          busy4, done4, co4;
  logic [W4-1:0] sum4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic chk_en = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b), .ci_i(ci),
    .busy_o(busy), .done_o(done), .sum_o(sum), .co_o(co)
  );

  serial_adder #(.WIDTH(W4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .a_i(a4), .b_i(b4), .ci_i(ci4),
    .busy_o(busy4), .done_o(done4), .sum_o(sum4), .co_o(co4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, got, exp);
    end
  endtask

  // Transaction model: an accepted start yields W busy cycles, then one done
  // cycle publishing (a+b+ci) split into sum and carry-out.
  int           m_left;
  logic         m_done;
  logic [W-1:0] m_sum;
  logic         m_co;
  logic [W:0]   m_pend;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_co   <= 1'b0;
    end else if (m_left == 0 && start) begin
      m_pend <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      m_left <= W;
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) {m_co, m_sum} <= m_pend;
    end else begin
      m_done <= 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_left > 0));
      check("done", 32'(done), 32'(m_done));
      check("sum",  32'(sum),  32'(m_sum));
      check("co",   32'(co),   32'(m_co));
      if (done) done_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_n++;
      tick(1);
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  // Accept one operation on the 8-bit DUT, then scramble the inputs.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    a = av; b = bv; ci = cv; start = 1'b1;
    tick(1);
    start = 1'b0;
    a = ~av; b = ~bv; ci = ~cv;
  endtask

  int n, bn, c1, d0;
  int order[512];
  logic [8:0] t;
  logic [4:0] exp4;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
    tick(2);
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_co",   32'(co),   32'd0);
    // start asserted together with reset is ignored
    start = 1'b1; a = 8'h11; b = 8'h22;
    tick(1);
    check("rst_start_ignored", 32'(busy), 32'd0);
    start = 1'b0; rst = 1'b0;
    tick(2);

    // 0x5A + 0x3C
    launch(8'h5A, 8'h3C, 1'b0);
    wait_done(n, bn);
    check("lat_030", 32'(n), 32'd8);
    check("busy_cycles_030", 32'(bn), 32'd8);
    check("sum_030", 32'(sum), 32'h96);
    check("co_030", 32'(co), 32'd0);
    check("model_sum_030", 32'(m_sum), 32'h96);
    tick(1);
    check("done_pulse_030", 32'(done), 32'd0);

    // overflow cases
    launch(8'hFF, 8'h01, 1'b0);
    wait_done(n, bn);
    check("sum_031a", 32'(sum), 32'h00);
    check("co_031a", 32'(co), 32'd1);
    launch(8'hFF, 8'hFF, 1'b1);
    wait_done(n, bn);
    check("sum_031b", 32'(sum), 32'hFF);
    check("co_031b", 32'(co), 32'd1);
    check("model_co_031b", 32'(m_co), 32'd1);
    tick(2);

    // start during RUN is ignored
    d0 = done_cnt;
    launch(8'h10, 8'h20, 1'b0);
    tick(3);
    a = 8'h01; b = 8'h01; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(n, bn);
    check("sum_032", 32'(sum), 32'h30);
    check("co_032", 32'(co), 32'd0);
    tick(12);
    check("done_count_032", 32'(done_cnt - d0), 32'd1);

    // reset mid-RUN discards the operation
    d0 = done_cnt;
    launch(8'h12, 8'h34, 1'b0);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_sum",  32'(sum),  32'd0);
    check("rst_mid_co",   32'(co),   32'd0);
    tick(12);
    check("done_count_033", 32'(done_cnt - d0), 32'd0);
    launch(8'h01, 8'h02, 1'b0);
    wait_done(n, bn);
    check("sum_033", 32'(sum), 32'h03);
    tick(2);

    // back-to-back with start held high
    a = 8'h01; b = 8'h01; ci = 1'b0; start = 1'b1;
    tick(1);
    a = 8'h80; b = 8'h80;
    wait_done(n, bn);
    check("lat_034", 32'(n), 32'd8);
    check("sum_034a", 32'(sum), 32'h02);
    check("co_034a", 32'(co), 32'd0);
    c1 = cyc;
    tick(1);
    wait_done(n, bn);
    check("period_034a", 32'(cyc - c1), 32'd9);
    check("sum_034b", 32'(sum), 32'h00);
    check("co_034b", 32'(co), 32'd1);
    c1 = cyc;
    tick(1);
    wait_done(n, bn);
    check("period_034b", 32'(cyc - c1), 32'd9);
    start = 1'b0;
    tick(3);

    // a few random operations checked by the model
    for (int i = 0; i < 6; i++) begin
      launch(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
      wait_done(n, bn);
      tick(1);
    end

    // exhaustive WIDTH=4 sweep in shuffled order
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j, tmp;
      j = int'($urandom_range(i, 0));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 512; i++) begin
      int k;
      t = 9'(order[i]);
      a4 = t[3:0]; b4 = t[7:4]; ci4 = t[8];
      exp4 = {1'b0, t[3:0]} + {1'b0, t[7:4]} + {4'd0, t[8]};
      start4 = 1'b1;
      tick(1);
      start4 = 1'b0;
      a4 = ~a4; b4 = ~b4; ci4 = ~ci4;
      k = 0;
      while (done4 !== 1'b1 && k < 20) begin
        tick(1);
        k++;
      end
      check("w4_result", 32'({co4, sum4}), 32'(exp4));
    end

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
